// File: rtl/cc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cc_bus_arbiter
// Purpose  : Two-core RAM arbiter that also sequences snoop and writeback
//            handshakes for coherent dcache misses.
// Revision : 1.0  initial release
// ============================================================================
module cc_bus_arbiter (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [31:0]      iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [31:0]      dload,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccexcl,
  input  logic [1:0]       ccdirty,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccwrite,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_IREAD  = 3'd1;
  localparam logic [2:0] c_DWRITE = 3'd2;
  localparam logic [2:0] c_SNOOP  = 3'd3;
  localparam logic [2:0] c_SNCHK  = 3'd4;
  localparam logic [2:0] c_CCWB   = 3'd5;
  localparam logic [2:0] c_DREAD  = 3'd6;

  localparam logic [1:0] c_ACCESS = 2'd2;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_g;
  logic       r_rr;
  logic       r_acc;
  logic       r_snp;
  logic       r_excl;

  logic       w_o;
  logic       w_access;
  logic [1:0] w_dreq;
  logic       w_win;
  logic       w_data;
  logic       w_any;
  logic       w_snooping;

  assign w_o      = ~r_g;
  assign w_access = (ramstate == c_ACCESS);
  assign w_dreq   = dREN | dWEN;
  assign iload    = ramload;
  assign dload    = ramload;

  // Data before instruction; within a class the rr core wins ties.
  always_comb begin
    w_win  = r_rr;
    w_data = 1'b0;
    w_any  = 1'b0;
    if (w_dreq[r_rr]) begin
      w_win = r_rr;  w_data = 1'b1; w_any = 1'b1;
    end else if (w_dreq[~r_rr]) begin
      w_win = ~r_rr; w_data = 1'b1; w_any = 1'b1;
    end else if (iREN[r_rr]) begin
      w_win = r_rr;  w_any = 1'b1;
    end else if (iREN[~r_rr]) begin
      w_win = ~r_rr; w_any = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_IDLE;
      r_g     <= 1'b0;
      r_rr    <= 1'b0;
      r_acc   <= 1'b0;
      r_snp   <= 1'b0;
      r_excl  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == c_IDLE && w_any) begin
        r_g    <= w_win;
        r_snp  <= (w_next == c_SNOOP);
        r_excl <= ccexcl[w_win];
      end
      // Writeback may only end once at least one word has been accepted.
      if (r_state == c_CCWB) begin
        if (w_access && dWEN[w_o])
          r_acc <= 1'b1;
      end else begin
        r_acc <= 1'b0;
      end
      if ((r_state == c_DWRITE || r_state == c_DREAD) && w_next == c_IDLE)
        r_rr <= ~r_rr;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_any) begin
          if (!w_data)              w_next = c_IREAD;
          else if (dWEN[w_win])     w_next = c_DWRITE;
          else if (cctrans[w_win])  w_next = c_SNOOP;
          else                      w_next = c_DREAD;
        end
      end
      c_IREAD:  if (w_access) w_next = c_IDLE;
      c_DWRITE: if (!dWEN[r_g]) w_next = c_IDLE;
      c_SNOOP:  w_next = c_SNCHK;
      c_SNCHK:  w_next = ccdirty[w_o] ? c_CCWB : c_DREAD;
      c_CCWB:   if (r_acc && !dWEN[w_o]) w_next = c_DREAD;
      c_DREAD:  if (!dREN[r_g]) w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  assign w_snooping = (r_state == c_SNOOP) || (r_state == c_SNCHK) ||
                      (r_state == c_CCWB)  || (r_state == c_DREAD && r_snp);

  always_comb begin
    iwait       = 2'b11;
    dwait       = 2'b11;
    ccwait      = 2'b00;
    ccwrite     = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'd0;
    ramstore    = 32'd0;
    if (w_snooping) begin
      ccwait[w_o]      = 1'b1;
      ccinv[w_o]       = r_excl;
      ccsnoopaddr[w_o] = daddr[r_g];
    end
    case (r_state)
      c_IREAD: begin
        ramREN       = 1'b1;
        ramaddr      = iaddr[r_g];
        iwait[r_g]   = ~w_access;
      end
      c_DWRITE: begin
        ramWEN       = dWEN[r_g];
        ramaddr      = daddr[r_g];
        ramstore     = dstore[r_g];
        dwait[r_g]   = ~(w_access & dWEN[r_g]);
      end
      c_CCWB: begin
        ccwrite[w_o] = 1'b1;
        ramWEN       = dWEN[w_o];
        ramaddr      = daddr[w_o];
        ramstore     = dstore[w_o];
        dwait[w_o]   = ~(w_access & dWEN[w_o]);
      end
      c_DREAD: begin
        ramREN       = dREN[r_g];
        ramaddr      = daddr[r_g];
        dwait[r_g]   = ~(w_access & dREN[r_g]);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_bus_arbiter
// Purpose  : Directed self-checking bench for cc_bus_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_cc_bus_arbiter;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [31:0]      iload;
  logic [1:0]       dREN, dWEN;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       dwait;
  logic [31:0]      dload;
  logic [1:0]       cctrans, ccexcl, ccdirty;
  logic [1:0]       ccwait, ccwrite, ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  cc_bus_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccexcl(ccexcl), .ccdirty(ccdirty),
    .ccwait(ccwait), .ccwrite(ccwrite), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccexcl = '0; ccdirty = '0; ramload = '0; ramstate = 2'd0;
    nxt; nxt;
    RST = 1'b0;

    // Reset, no requests
    for (int k = 0; k < 10; k++) begin
      nxt; #1;
      check("rst dwait", dwait, 32'h3);
      check("rst iwait", iwait, 32'h3);
      check("rst ram en", {ramREN, ramWEN}, 32'h0);
      check("rst ccwait", ccwait, 32'h0);
      check("rst state", dut.r_state, 32'h0);
    end
    check("rst ramaddr", ramaddr, 32'h0);

    // Core0 clean coherent miss at 0x100
    dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h100; #1;
    check("s2 idle dwait", dwait, 32'h3);
    nxt; #1;
    check("s2 snoop ccwait", ccwait, 32'h2);
    check("s2 snoop addr", ccsnoopaddr[1], 32'h100);
    check("s2 snoop ccinv", ccinv, 32'h0);
    check("s2 snoop ramREN", ramREN, 32'h0);
    nxt; #1;
    check("s2 snchk ccwait", ccwait, 32'h2);
    check("s2 snchk ramREN", ramREN, 32'h0);
    nxt; ramstate = 2'd1; #1;
    check("s2 w0 ramREN", ramREN, 32'h1);
    check("s2 w0 ramaddr", ramaddr, 32'h100);
    check("s2 w0 busy dwait", dwait, 32'h3);
    check("s2 dread ccwait", ccwait, 32'h2);
    nxt; ramstate = 2'd2; ramload = 32'hAAAA0001; #1;
    check("s2 w0 dwait", dwait, 32'h2);
    check("s2 w0 dload", dload, 32'hAAAA0001);
    check("s2 w0 iload", iload, 32'hAAAA0001);
    nxt; daddr[0] = 32'h104; ramstate = 2'd1; #1;
    check("s2 w1 ramaddr", ramaddr, 32'h104);
    check("s2 w1 busy dwait", dwait, 32'h3);
    nxt; ramstate = 2'd2; ramload = 32'hAAAA0002; #1;
    check("s2 w1 dwait", dwait, 32'h2);
    check("s2 w1 dload", dload, 32'hAAAA0002);
    nxt; dREN = 2'b00; cctrans = 2'b00; ramstate = 2'd0; #1;
    check("s2 drop ramREN", ramREN, 32'h0);
    check("s2 drop ccwait", ccwait, 32'h2);
    nxt; #1;
    check("s2 end ccwait", ccwait, 32'h0);
    check("s2 end dwait", dwait, 32'h3);
    check("s2 rr", dut.r_rr, 32'h1);

    // Core0 exclusive miss at 0x200, core1 holds it dirty
    dREN = 2'b01; cctrans = 2'b01; ccexcl = 2'b01; daddr[0] = 32'h200;
    nxt; #1;
    check("s3 snoop ccwait", ccwait, 32'h2);
    check("s3 snoop ccinv", ccinv, 32'h2);
    check("s3 snoop addr", ccsnoopaddr[1], 32'h200);
    check("s3 snoop ccwrite", ccwrite, 32'h0);
    nxt; ccdirty = 2'b10; #1;
    check("s3 snchk ccinv", ccinv, 32'h2);
    check("s3 snchk ram en", {ramREN, ramWEN}, 32'h0);
    nxt; dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'hD0D00001; ramstate = 2'd1; #1;
    check("s3 wb ccwrite", ccwrite, 32'h2);
    check("s3 wb ccinv", ccinv, 32'h2);
    check("s3 wb ram en", {ramREN, ramWEN}, 32'h1);
    check("s3 wb0 ramaddr", ramaddr, 32'h200);
    check("s3 wb0 ramstore", ramstore, 32'hD0D00001);
    check("s3 wb0 busy dwait", dwait, 32'h3);
    nxt; ramstate = 2'd2; #1;
    check("s3 wb0 dwait", dwait, 32'h1);
    nxt; daddr[1] = 32'h204; dstore[1] = 32'hD0D00002; ramstate = 2'd1; #1;
    check("s3 wb1 ramaddr", ramaddr, 32'h204);
    check("s3 wb1 ramREN", ramREN, 32'h0);
    nxt; ramstate = 2'd2; #1;
    check("s3 wb1 dwait", dwait, 32'h1);
    check("s3 wb1 ramstore", ramstore, 32'hD0D00002);
    nxt; dWEN = 2'b00; ccdirty = 2'b00; ramstate = 2'd0; #1;
    check("s3 wb end ramWEN", ramWEN, 32'h0);
    check("s3 wb end ccwrite", ccwrite, 32'h2);
    nxt; ramstate = 2'd1; #1;
    check("s3 rd ramREN", ramREN, 32'h1);
    check("s3 rd0 ramaddr", ramaddr, 32'h200);
    check("s3 rd ccwrite", ccwrite, 32'h0);
    check("s3 rd ccwait", ccwait, 32'h2);
    nxt; ramstate = 2'd2; ramload = 32'hBBBB0001; #1;
    check("s3 rd0 dwait", dwait, 32'h2);
    check("s3 rd0 dload", dload, 32'hBBBB0001);
    nxt; daddr[0] = 32'h204; ramstate = 2'd1; #1;
    check("s3 rd1 ramaddr", ramaddr, 32'h204);
    nxt; ramstate = 2'd2; #1;
    check("s3 rd1 dwait", dwait, 32'h2);
    nxt; dREN = 2'b00; cctrans = 2'b00; ccexcl = 2'b00; ramstate = 2'd0; #1;
    nxt; #1;
    check("s3 end ccwait", ccwait, 32'h0);
    check("s3 end ccinv", ccinv, 32'h0);
    check("s3 rr", dut.r_rr, 32'h0);

    // Both cores contend for 8 rounds; grants must alternate from core0
    daddr[0] = 32'h400; daddr[1] = 32'h500;
    for (int r = 0; r < 8; r++) begin
      int w;
      logic [1:0] e_dw;
      w = r % 2;
      e_dw = 2'b11;
      e_dw[w] = 1'b0;
      dREN = 2'b11; #1;
      check("s4 idle ramREN", ramREN, 32'h0);
      nxt; ramstate = 2'd2; #1;
      check("s4 grant ramaddr", ramaddr, (w == 1) ? 32'h500 : 32'h400);
      check("s4 grant dwait", dwait, e_dw);
      nxt; dREN[w] = 1'b0; ramstate = 2'd0; #1;
      nxt;
    end
    dREN = 2'b00;

    // iREN[0] and dWEN[1] together: write first, then fetch
    iREN = 2'b01; iaddr[0] = 32'h800;
    dWEN = 2'b10; daddr[1] = 32'h900; dstore[1] = 32'h1234; #1;
    check("s5 idle iwait", iwait, 32'h3);
    nxt; ramstate = 2'd2; #1;
    check("s5 wr ramWEN", ramWEN, 32'h1);
    check("s5 wr ramaddr", ramaddr, 32'h900);
    check("s5 wr ramstore", ramstore, 32'h1234);
    check("s5 wr dwait", dwait, 32'h1);
    check("s5 wr iwait", iwait, 32'h3);
    nxt; dWEN = 2'b00; ramstate = 2'd0; #1;
    check("s5 wr end iwait", iwait, 32'h3);
    nxt; #1;
    check("s5 idle2 ramREN", ramREN, 32'h0);
    nxt; ramstate = 2'd1; #1;
    check("s5 ird ramREN", ramREN, 32'h1);
    check("s5 ird ramaddr", ramaddr, 32'h800);
    check("s5 ird busy iwait", iwait, 32'h3);
    nxt; ramstate = 2'd2; ramload = 32'hCAFEF00D; #1;
    check("s5 ird iwait", iwait, 32'h2);
    check("s5 ird iload", iload, 32'hCAFEF00D);
    nxt; iREN = 2'b00; ramstate = 2'd0; #1;
    check("s5 end ramREN", ramREN, 32'h0);
    check("s5 end iwait", iwait, 32'h3);

    // Reset in the middle of a dirty writeback
    dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h600;
    nxt;
    nxt; ccdirty = 2'b10; #1;
    nxt; dWEN = 2'b10; daddr[1] = 32'h600; ramstate = 2'd1; #1;
    check("s6 ccwb ramWEN", ramWEN, 32'h1);
    check("s6 ccwb ccwrite", ccwrite, 32'h2);
    RST = 1'b1;
    nxt; #1;
    check("s6 rst ccwait", ccwait, 32'h0);
    check("s6 rst ccwrite", ccwrite, 32'h0);
    check("s6 rst ramWEN", ramWEN, 32'h0);
    check("s6 rst dwait", dwait, 32'h3);
    check("s6 rst state", dut.r_state, 32'h0);
    RST = 1'b0;
    dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccdirty = 2'b00; ramstate = 2'd0;
    nxt;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
